// File: rtl/display_scheduler_if.sv
// Bundle between the display sources / alert requester and the display scheduler.
// The master side owns the sources and the alert request; the slave side is the
// scheduler that produces the seven-segment value.
interface display_scheduler_if #(
    parameter int NUM_SRC = 4
);
    localparam int AW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]    src_valid;
    logic [32*NUM_SRC-1:0] src_data;
    logic                  auto_en;
    logic                  next_btn;
    logic                  alert_req;
    logic [31:0]           alert_data;
    logic                  alert_ack;
    logic                  alert_active;
    logic [AW-1:0]         active_src;
    logic [31:0]           hex;

    modport master (
        output src_valid, src_data, auto_en, next_btn, alert_req, alert_data,
        input  alert_ack, alert_active, active_src, hex
    );

    modport slave (
        input  src_valid, src_data, auto_en, next_btn, alert_req, alert_data,
        output alert_ack, alert_active, active_src, hex
    );
endinterface

// File: rtl/display_scheduler.sv
// Time-multiplexes NUM_SRC 32-bit display sources onto one 8-digit hex value.
// Round-robin over valid sources on a dwell timer or a button edge; a one-shot
// alert preempts rotation for ALERT_CYCLES cycles and is acknowledged by a pulse.
// Every output is a flop; hex lags the state/active_src registers by one cycle.
module display_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL        = 2000,
    parameter int ALERT_CYCLES = 3000
) (
    input  logic                 slow_clk,
    input  logic                 reset,
    display_scheduler_if.slave   bus
);
    localparam int AW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int DW = $clog2(DWELL);
    localparam int CW = $clog2(ALERT_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [CW-1:0] ALERT_LAST = CW'(ALERT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        ALERT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] active_q, active_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] alert_cnt_q, alert_cnt_d;
    logic [31:0]   alert_q, alert_d;
    logic [31:0]   hex_q, hex_d;
    logic          alert_active_q;
    logic          alert_ack_q, alert_ack_d;
    logic          armed_q, armed_d;
    logic          btn_prev_q;

    logic [31:0]   src_slice [NUM_SRC];
    logic [AW:0]   next_pick;
    logic          next_found;
    logic [AW-1:0] next_idx;
    logic          btn_rise;
    logic          alert_go;
    logic          advance;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slice
        assign src_slice[g] = bus.src_data[32*g +: 32];
    end

    // First valid index after cur, scanning upward and wrapping; cur itself is
    // the last candidate. MSB of the result flags that something was found.
    function automatic logic [AW:0] find_next(input logic [AW-1:0]      cur,
                                              input logic [NUM_SRC-1:0] valid);
        logic [AW:0] cand;
        logic [AW:0] result;
        result = {1'b0, cur};
        // Scanning from the far end down lets the nearest hit overwrite the rest.
        for (int i = NUM_SRC; i >= 1; i--) begin
            cand = {1'b0, cur} + (AW+1)'(i);
            if (cand >= (AW+1)'(NUM_SRC)) begin
                cand = cand - (AW+1)'(NUM_SRC);
            end
            if (valid[cand[AW-1:0]]) begin
                result = {1'b1, cand[AW-1:0]};
            end
        end
        return result;
    endfunction

    assign next_pick  = find_next(active_q, bus.src_valid);
    assign next_found = next_pick[AW];
    assign next_idx   = next_pick[AW-1:0];
    assign btn_rise   = bus.next_btn & ~btn_prev_q;
    assign alert_go   = bus.alert_req & armed_q;
    assign advance    = btn_rise
                      | (bus.auto_en & (dwell_q == DWELL_LAST))
                      | ~bus.src_valid[active_q];

    // Next-state and next-output decode for the scheduler FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        active_d    = active_q;
        dwell_d     = '0;
        alert_cnt_d = '0;
        alert_d     = alert_q;
        alert_ack_d = 1'b0;
        // A low request re-arms; a held request keeps the alert one-shot.
        armed_d     = armed_q | ~bus.alert_req;

        unique case (state_q)
            IDLE: begin
                if (alert_go) begin
                    state_d = ALERT;
                    alert_d = bus.alert_data;
                    armed_d = 1'b0;
                end else if (next_found) begin
                    state_d  = SHOW;
                    active_d = next_idx;
                end
            end
            SHOW: begin
                if (alert_go) begin
                    state_d = ALERT;
                    alert_d = bus.alert_data;
                    armed_d = 1'b0;
                end else if (advance) begin
                    if (next_found) begin
                        active_d = next_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.auto_en) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ALERT: begin
                if (alert_cnt_q == ALERT_LAST) begin
                    alert_ack_d = 1'b1;
                    if (bus.src_valid[active_q]) begin
                        state_d = SHOW;
                    end else if (next_found) begin
                        state_d  = SHOW;
                        active_d = next_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    alert_cnt_d = alert_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_q)
            SHOW:    hex_d = src_slice[active_q];
            ALERT:   hex_d = alert_q;
            default: hex_d = '0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge slow_clk) begin
        // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
        if (reset) begin
            state_q        <= IDLE;
            active_q       <= '0;
            dwell_q        <= '0;
            alert_cnt_q    <= '0;
            alert_q        <= '0;
            hex_q          <= '0;
            alert_active_q <= 1'b0;
            alert_ack_q    <= 1'b0;
            armed_q        <= 1'b1;
            // A button already held through reset must not count as an edge.
            btn_prev_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            dwell_q        <= dwell_d;
            alert_cnt_q    <= alert_cnt_d;
            alert_q        <= alert_d;
            hex_q          <= hex_d;
            alert_active_q <= (state_d == ALERT);
            alert_ack_q    <= alert_ack_d;
            armed_q        <= armed_d;
            btn_prev_q     <= bus.next_btn;
        end
    end

    assign bus.hex          = hex_q;
    assign bus.active_src   = active_q;
    assign bus.alert_active = alert_active_q;
    assign bus.alert_ack    = alert_ack_q;
endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler (NUM_SRC=4, DWELL=4, ALERT_CYCLES=3).
// Stimulus pushes hand-computed expectations tagged with the cycle they apply to;
// a monitor on the falling edge pops and compares them against the outputs.
module tb_display_scheduler;
    typedef struct {
        int          cyc;
        string       name;
        logic [1:0]  as;
        logic [31:0] hex;
        logic        aa;
        logic        ack;
    } exp_t;

    logic   slow_clk;
    logic   reset;
    int     cyc;
    int     checks;
    int     errors;
    int     ack_seen;
    exp_t   sb[$];

    display_scheduler_if #(.NUM_SRC(4)) bus ();

    display_scheduler #(
        .NUM_SRC      (4),
        .DWELL        (4),
        .ALERT_CYCLES (3)
    ) dut (
        .slow_clk (slow_clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial begin
        slow_clk = 1'b0;
        forever #5 slow_clk = ~slow_clk;
    end

    // Edge counter: value N is visible between rising edge N and N+1.
    always @(posedge slow_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Queue an expectation k edges from now, kept sorted by cycle.
    task automatic expect_at(input int k, input string nm, input logic [1:0] as,
                             input logic [31:0] hx, input logic aa, input logic ack);
        exp_t e;
        int   pos;
        e.cyc  = cyc + k;
        e.name = nm;
        e.as   = as;
        e.hex  = hx;
        e.aa   = aa;
        e.ack  = ack;
        pos = sb.size();
        while (pos > 0 && sb[pos-1].cyc > e.cyc) pos--;
        sb.insert(pos, e);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge slow_clk);
            #2;
        end
    endtask

    // Monitor: compare due expectations and count acknowledge pulses.
    always @(negedge slow_clk) begin
        if (bus.alert_ack === 1'b1) ack_seen++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: stale expectation for cycle %0d seen at %0d", e.name, e.cyc, cyc);
            end else begin
                check({e.name, ".active_src"},   32'(bus.active_src),   32'(e.as));
                check({e.name, ".hex"},          bus.hex,               e.hex);
                check({e.name, ".alert_active"}, 32'(bus.alert_active), 32'(e.aa));
                check({e.name, ".alert_ack"},    32'(bus.alert_ack),    32'(e.ack));
            end
        end
    end

    initial begin
        cyc            = 0;
        checks         = 0;
        errors         = 0;
        ack_seen       = 0;
        reset          = 1'b1;
        bus.src_valid  = '0;
        bus.src_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        bus.auto_en    = 1'b0;
        bus.next_btn   = 1'b0;
        bus.alert_req  = 1'b0;
        bus.alert_data = '0;

        // Reset values, then auto rotation over all four sources.
        tick();
        expect_at(0, "reset0", 2'd0, 32'h0, 1'b0, 1'b0);
        bus.src_valid = 4'b1111;
        bus.auto_en   = 1'b1;
        tick();
        expect_at(0, "reset1", 2'd0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        expect_at(1,  "auto_enter", 2'd1, 32'h00000000, 1'b0, 1'b0);
        expect_at(2,  "auto_s1a",   2'd1, 32'h22222222, 1'b0, 1'b0);
        expect_at(4,  "auto_s1b",   2'd1, 32'h22222222, 1'b0, 1'b0);
        expect_at(5,  "auto_s2a",   2'd2, 32'h22222222, 1'b0, 1'b0);
        expect_at(6,  "auto_s2b",   2'd2, 32'h33333333, 1'b0, 1'b0);
        expect_at(9,  "auto_s3a",   2'd3, 32'h33333333, 1'b0, 1'b0);
        expect_at(10, "auto_s3b",   2'd3, 32'h44444444, 1'b0, 1'b0);
        expect_at(13, "auto_s0a",   2'd0, 32'h44444444, 1'b0, 1'b0);
        expect_at(14, "auto_s0b",   2'd0, 32'h11111111, 1'b0, 1'b0);
        expect_at(17, "auto_wrap",  2'd1, 32'h11111111, 1'b0, 1'b0);
        tick(17);

        // Sparse valid set, manual mode: no change without button edges.
        bus.src_valid = 4'b1010;
        bus.auto_en   = 1'b0;
        expect_at(1, "manual_hold0", 2'd1, 32'h22222222, 1'b0, 1'b0);
        expect_at(5, "manual_hold1", 2'd1, 32'h22222222, 1'b0, 1'b0);
        tick(5);
        bus.src_data[63:32] = 32'h0BADF00D;
        expect_at(1, "live_data", 2'd1, 32'h0BADF00D, 1'b0, 1'b0);
        tick();
        bus.src_data[63:32] = 32'h22222222;
        expect_at(1, "live_restore", 2'd1, 32'h22222222, 1'b0, 1'b0);
        tick();
        bus.next_btn = 1'b1;
        expect_at(1, "btn_to3a", 2'd3, 32'h22222222, 1'b0, 1'b0);
        expect_at(2, "btn_to3b", 2'd3, 32'h44444444, 1'b0, 1'b0);
        tick();
        bus.next_btn = 1'b0;
        tick(4);
        bus.next_btn = 1'b1;
        expect_at(1, "btn_to1a", 2'd1, 32'h44444444, 1'b0, 1'b0);
        expect_at(2, "btn_to1b", 2'd1, 32'h22222222, 1'b0, 1'b0);
        expect_at(3, "btn_held", 2'd1, 32'h22222222, 1'b0, 1'b0);
        tick(3);
        bus.next_btn = 1'b0;
        tick();

        // Source drop: forced advance, then everything invalid goes idle.
        bus.src_valid = 4'b1111;
        bus.next_btn  = 1'b1;
        expect_at(1, "drop_at2a", 2'd2, 32'h22222222, 1'b0, 1'b0);
        expect_at(2, "drop_at2b", 2'd2, 32'h33333333, 1'b0, 1'b0);
        tick();
        bus.next_btn = 1'b0;
        tick();
        bus.src_valid = 4'b1011;
        expect_at(1, "drop_to3a", 2'd3, 32'h33333333, 1'b0, 1'b0);
        expect_at(2, "drop_to3b", 2'd3, 32'h44444444, 1'b0, 1'b0);
        tick(2);
        bus.src_valid = 4'b0000;
        expect_at(1, "drop_idle0", 2'd3, 32'h44444444, 1'b0, 1'b0);
        expect_at(2, "drop_idle1", 2'd3, 32'h00000000, 1'b0, 1'b0);
        expect_at(4, "drop_idle2", 2'd3, 32'h00000000, 1'b0, 1'b0);
        tick(4);

        // Alert handshake with the request held high.
        bus.src_valid = 4'b1111;
        expect_at(1, "idle_exit0", 2'd0, 32'h00000000, 1'b0, 1'b0);
        expect_at(2, "idle_exit1", 2'd0, 32'h11111111, 1'b0, 1'b0);
        tick(2);
        bus.alert_data = 32'hDEADBEEF;
        bus.alert_req  = 1'b1;
        expect_at(1, "alert_enter", 2'd0, 32'h11111111, 1'b1, 1'b0);
        expect_at(2, "alert_hold0", 2'd0, 32'hDEADBEEF, 1'b1, 1'b0);
        expect_at(3, "alert_hold1", 2'd0, 32'hDEADBEEF, 1'b1, 1'b0);
        expect_at(4, "alert_ack",   2'd0, 32'hDEADBEEF, 1'b0, 1'b1);
        expect_at(5, "alert_resume", 2'd0, 32'h11111111, 1'b0, 1'b0);
        expect_at(8, "alert_noretrig", 2'd0, 32'h11111111, 1'b0, 1'b0);
        tick(8);
        bus.alert_req = 1'b0;
        tick();
        bus.alert_req  = 1'b1;
        bus.alert_data = 32'h12345678;
        expect_at(1, "rearm_enter", 2'd0, 32'h11111111, 1'b1, 1'b0);
        expect_at(2, "rearm_hold",  2'd0, 32'h12345678, 1'b1, 1'b0);
        expect_at(4, "rearm_ack",   2'd0, 32'h12345678, 1'b0, 1'b1);
        expect_at(5, "rearm_resume", 2'd0, 32'h11111111, 1'b0, 1'b0);
        tick();
        bus.alert_req = 1'b0;
        tick(5);

        // Alert, button edge and dwell expiry all land on the same edge.
        bus.auto_en = 1'b1;
        expect_at(1, "simul_pre0", 2'd0, 32'h11111111, 1'b0, 1'b0);
        expect_at(3, "simul_pre1", 2'd0, 32'h11111111, 1'b0, 1'b0);
        tick(3);
        bus.next_btn   = 1'b1;
        bus.alert_req  = 1'b1;
        bus.alert_data = 32'hA5A5A5A5;
        expect_at(1, "simul_enter",  2'd0, 32'h11111111, 1'b1, 1'b0);
        expect_at(2, "simul_hold",   2'd0, 32'hA5A5A5A5, 1'b1, 1'b0);
        expect_at(4, "simul_ack",    2'd0, 32'hA5A5A5A5, 1'b0, 1'b1);
        expect_at(5, "simul_after0", 2'd0, 32'h11111111, 1'b0, 1'b0);
        expect_at(6, "simul_after1", 2'd0, 32'h11111111, 1'b0, 1'b0);
        tick();
        bus.auto_en   = 1'b0;
        bus.alert_req = 1'b0;
        tick(5);

        // Reset during an alert with the button still held high.
        bus.alert_req  = 1'b1;
        bus.alert_data = 32'h77777777;
        expect_at(1, "rst_alert", 2'd0, 32'h11111111, 1'b1, 1'b0);
        expect_at(2, "rst_mid0",  2'd0, 32'h00000000, 1'b0, 1'b0);
        expect_at(3, "rst_mid1",  2'd0, 32'h00000000, 1'b0, 1'b0);
        expect_at(4, "rst_rel0",  2'd1, 32'h00000000, 1'b0, 1'b0);
        expect_at(5, "rst_rel1",  2'd1, 32'h22222222, 1'b0, 1'b0);
        expect_at(8, "rst_rel2",  2'd1, 32'h22222222, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick(2);
        reset         = 1'b0;
        bus.alert_req = 1'b0;
        tick(6);

        // Drain whatever is still pending, with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never reached, expected 0", sb.size());
        end
        check("ack_pulses", 32'(ack_seen), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
